// File: rtl/core_db_pkg.sv
// core_db_pkg
// Shared widths and FSM state types for the dual-rail accumulator wrapper.
//   W     : number of dual-rail digits (accumulator width)
//   DR_W  : number of rails on each channel (2 per digit)
//   in_state_e  : input handshake states
//   out_state_e : output handshake states
package core_db_pkg;

    localparam int W    = 7;
    localparam int DR_W = 14;

    typedef enum logic {
        IN_WAIT = 1'b0,
        IN_ACK  = 1'b1
    } in_state_e;

    typedef enum logic [1:0] {
        OUT_IDLE = 2'd0,
        OUT_DATA = 2'd1,
        OUT_RTZ  = 2'd2
    } out_state_e;

endpackage

// File: rtl/core_db_dr_codec.sv
// core_db_dr_codec
// Purely combinational 1-of-2 dual-rail codec.
// Digit i lives on rails [2i] (rail "0") and [2i+1] (rail "1").
//   dr_i      in  DR_W  dual-rail word to classify and decode
//   val_i     in  W     binary value to encode
//   val_o     out W     decoded binary value (meaningful only when valid_o)
//   valid_o   out 1     every digit has exactly one rail high
//   neutral_o out 1     all rails low
//   illegal_o out 1     at least one digit has both rails high
//   dr_o      out DR_W  dual-rail encoding of val_i
module core_db_dr_codec
    import core_db_pkg::*;
(
    input  logic [DR_W-1:0] dr_i,
    input  logic [W-1:0]    val_i,
    output logic [W-1:0]    val_o,
    output logic            valid_o,
    output logic            neutral_o,
    output logic            illegal_o,
    output logic [DR_W-1:0] dr_o
);

    always_comb begin
        val_o     = '0;
        valid_o   = 1'b1;
        illegal_o = 1'b0;
        dr_o      = '0;
        for (int i = 0; i < W; i++) begin
            val_o[i]     = dr_i[2*i+1];
            valid_o      = valid_o & (dr_i[2*i] ^ dr_i[2*i+1]);
            illegal_o    = illegal_o | (dr_i[2*i] & dr_i[2*i+1]);
            dr_o[2*i]    = ~val_i[i];
            dr_o[2*i+1]  = val_i[i];
        end
    end

    assign neutral_o = ~|dr_i;

endmodule

// File: rtl/core_db_cosim_wrapper.sv
// core_db_cosim_wrapper
// Clocked bridge between two four-phase return-to-zero dual-rail channels.
// Each accepted input token is added (mod 128) into an accumulator and the
// new sum is emitted on the output channel through a one-entry buffer.
//   CLK          in  1     sole clock, rising edge
//   _RESET       in  1     asynchronous active-low reset
//   datain_d     in  14    input dual-rail channel (asynchronous to CLK)
//   datain_e     out 1     input enable: 1 = ready, 0 = token acknowledged
//   dataout_d    out 14    output dual-rail channel, driven from flops
//   dataout_e    in  1     consumer enable (asynchronous to CLK)
//   protocol_err out 1     sticky illegal-digit flag
// Build option: define CORE_DB_ERRCHK_EN to make protocol_err live; when
// undefined it is tied low. Illegal digits are never accepted either way.
module core_db_cosim_wrapper
    import core_db_pkg::*;
(
    input  logic            CLK,
    input  logic            _RESET,
    input  logic [DR_W-1:0] datain_d,
    output logic            datain_e,
    output logic [DR_W-1:0] dataout_d,
    input  logic            dataout_e,
    output logic            protocol_err
);

    logic [DR_W-1:0] din_s1_q, din_s2_q;
    logic            oe_s1_q, oe_s2_q;
    in_state_e       in_state_q;
    out_state_e      out_state_q;
    logic [W-1:0]    acc_q;
    logic [W-1:0]    buf_q;
    logic            buf_full_q;
    logic            datain_e_q;
    logic [DR_W-1:0] dataout_q;

    logic [W-1:0]    in_val;
    logic            in_valid, in_neutral, in_illegal;
    logic [DR_W-1:0] buf_dr;
    logic [W-1:0]    acc_sum;
    logic            accept;

    core_db_dr_codec u_codec (
        .dr_i      (din_s2_q),
        .val_i     (buf_q),
        .val_o     (in_val),
        .valid_o   (in_valid),
        .neutral_o (in_neutral),
        .illegal_o (in_illegal),
        .dr_o      (buf_dr)
    );

    // 7-bit add wraps naturally, giving the mod-128 accumulate.
    assign acc_sum = acc_q + in_val;
    // Buffer-full check uses the registered flag, so a token is never taken
    // on the same edge the output side empties the buffer.
    assign accept  = (in_state_q == IN_WAIT) && in_valid && !in_illegal && !buf_full_q;

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            din_s1_q    <= '0;
            din_s2_q    <= '0;
            oe_s1_q     <= 1'b0;
            oe_s2_q     <= 1'b0;
            in_state_q  <= IN_WAIT;
            out_state_q <= OUT_IDLE;
            acc_q       <= '0;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
            datain_e_q  <= 1'b0;
            dataout_q   <= '0;
        end else begin
            din_s1_q <= datain_d;
            din_s2_q <= din_s1_q;
            oe_s1_q  <= dataout_e;
            oe_s2_q  <= oe_s1_q;

            case (in_state_q)
                IN_WAIT: begin
                    if (accept) begin
                        in_state_q <= IN_ACK;
                        datain_e_q <= 1'b0;
                        acc_q      <= acc_sum;
                        buf_q      <= acc_sum;
                        buf_full_q <= 1'b1;
                    end else begin
                        // Also produces the first rise of datain_e after reset.
                        datain_e_q <= 1'b1;
                    end
                end
                IN_ACK: begin
                    if (in_neutral) begin
                        in_state_q <= IN_WAIT;
                        datain_e_q <= 1'b1;
                    end
                end
            endcase

            case (out_state_q)
                OUT_IDLE: begin
                    if (buf_full_q && oe_s2_q) begin
                        out_state_q <= OUT_DATA;
                        dataout_q   <= buf_dr;
                    end
                end
                OUT_DATA: begin
                    if (!oe_s2_q) begin
                        out_state_q <= OUT_RTZ;
                        dataout_q   <= '0;
                        buf_full_q  <= 1'b0;
                    end
                end
                OUT_RTZ: begin
                    if (oe_s2_q) begin
                        out_state_q <= OUT_IDLE;
                    end
                end
                default: begin
                    out_state_q <= OUT_IDLE;
                    dataout_q   <= '0;
                end
            endcase
        end
    end

    assign datain_e  = datain_e_q;
    assign dataout_d = dataout_q;

`ifdef CORE_DB_ERRCHK_EN
    logic err_q;

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            err_q <= 1'b0;
        end else if (in_illegal) begin
            err_q <= 1'b1;
        end
    end

    assign protocol_err = err_q;
`else
    assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_core_db_cosim_wrapper.sv
module tb_core_db_cosim_wrapper;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] datain_d;
    logic        datain_e;
    logic [13:0] dataout_d;
    logic        dataout_e;
    logic        protocol_err;

    int   total = 0;
    int   bad   = 0;
    int   acc_m = 0;
    logic exp_err = 1'b0;

    always #5 clk = ~clk;

    core_db_cosim_wrapper dut (
        .CLK          (clk),
        ._RESET       (rst_n),
        .datain_d     (datain_d),
        .datain_e     (datain_e),
        .dataout_d    (dataout_d),
        .dataout_e    (dataout_e),
        .protocol_err (protocol_err)
    );

    function automatic logic [13:0] enc(int v);
        logic [13:0] r;
        r = '0;
        for (int i = 0; i < 7; i++) begin
            if (((v >> i) & 1) != 0) r[2*i+1] = 1'b1;
            else                     r[2*i]   = 1'b1;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_e(input logic v);
        for (int i = 0; i < 100 && datain_e !== v; i++) @(negedge clk);
    endtask

    task automatic wait_dout_valid();
        for (int i = 0; i < 100 && dataout_d === 14'h0; i++) @(negedge clk);
    endtask

    task automatic wait_dout_zero();
        for (int i = 0; i < 100 && dataout_d !== 14'h0; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        datain_d = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        acc_m = 0;
        exp_err = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    // Full four-phase handshake on both channels for one token.
    task automatic xfer(input int a, input bit lat);
        @(negedge clk);
        datain_d = enc(a);
        acc_m = (acc_m + a) % 128;
        if (lat) begin
            @(posedge clk); #1 chk("lat_edge1", datain_e, 1);
            @(posedge clk); #1 chk("lat_edge2", datain_e, 1);
            @(posedge clk); #1 chk("lat_ack_edge3", datain_e, 0);
            chk("lat_out_not_yet", dataout_d, 0);
            @(posedge clk); #1 chk("lat_out_edge4", dataout_d, enc(acc_m));
        end
        wait_e(1'b0);
        chk("ack", datain_e, 0);
        wait_dout_valid();
        chk("dout", dataout_d, enc(acc_m));
        @(negedge clk);
        datain_d  = '0;
        dataout_e = 1'b0;
        wait_dout_zero();
        chk("dout_rtz", dataout_d, 0);
        wait_e(1'b1);
        chk("in_release", datain_e, 1);
        dataout_e = 1'b1;
        chk("perr", protocol_err, exp_err);
    endtask

    initial begin
        int a, a2, k, e1;
        logic [13:0] d;

        rst_n     = 1'b0;
        datain_d  = '0;
        dataout_e = 1'b1;
        #400;
        chk("rst_datain_e", datain_e, 0);
        chk("rst_dataout_d", dataout_d, 0);
        chk("rst_perr", protocol_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1 chk("rise_after_reset", datain_e, 1);
        repeat (3) @(negedge clk);

        // Tokens 1,2,3 -> sums 1,3,6
        xfer(1, 1);
        xfer(2, 0);
        xfer(3, 0);

        // Tokens 1..16 -> wrap to 8 on the 16th
        do_reset();
        for (int t = 1; t <= 16; t++) xfer(t, 0);

        // Random tokens
        repeat (8) begin
            a = int'($urandom_range(0, 127));
            xfer(a, 0);
        end

        // Partial codeword: one digit neutral
        a = int'($urandom_range(0, 127));
        k = int'($urandom_range(0, 6));
        d = enc(a);
        d[2*k +: 2] = 2'b00;
        @(negedge clk);
        datain_d = d;
        repeat (20) @(negedge clk);
        chk("partial_no_ack", datain_e, 1);
        chk("partial_no_out", dataout_d, 0);
        xfer(a, 0);

        // Backpressure: consumer holds enable low
        @(negedge clk);
        dataout_e = 1'b0;
        repeat (4) @(negedge clk);
        a = int'($urandom_range(0, 127));
        datain_d = enc(a);
        acc_m = (acc_m + a) % 128;
        e1 = acc_m;
        wait_e(1'b0);
        chk("bp_ack1", datain_e, 0);
        @(negedge clk);
        datain_d = '0;
        wait_e(1'b1);
        chk("bp_rel1", datain_e, 1);
        chk("bp_out_held", dataout_d, 0);
        a2 = int'($urandom_range(0, 127));
        datain_d = enc(a2);
        repeat (30) @(negedge clk);
        chk("bp_no_ack2", datain_e, 1);
        dataout_e = 1'b1;
        wait_dout_valid();
        chk("bp_dout1", dataout_d, enc(e1));
        @(negedge clk);
        dataout_e = 1'b0;
        wait_e(1'b0);
        chk("bp_ack2", datain_e, 0);
        acc_m = (acc_m + a2) % 128;
        @(negedge clk);
        datain_d = '0;
        wait_e(1'b1);
        chk("bp_rel2", datain_e, 1);
        dataout_e = 1'b1;
        wait_dout_valid();
        chk("bp_dout2", dataout_d, enc(acc_m));
        @(negedge clk);
        dataout_e = 1'b0;
        wait_dout_zero();
        dataout_e = 1'b1;
        repeat (4) @(negedge clk);

        // Illegal digit 0 = 2'b11
        a = int'($urandom_range(0, 127));
        d = enc(a);
        d[1:0] = 2'b11;
        datain_d = d;
        repeat (20) @(negedge clk);
        chk("illegal_no_ack", datain_e, 1);
`ifdef CORE_DB_ERRCHK_EN
        exp_err = 1'b1;
`endif
        chk("illegal_perr", protocol_err, exp_err);
        datain_d = '0;
        repeat (5) @(negedge clk);
        a = int'($urandom_range(0, 127));
        xfer(a, 0);

        // Reset while the output is presenting data
        @(negedge clk);
        datain_d = enc(9);
        wait_e(1'b0);
        wait_dout_valid();
        chk("mid_dout", dataout_d, enc((acc_m + 9) % 128));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_dout", dataout_d, 0);
        chk("mid_rst_datain_e", datain_e, 0);
        chk("mid_rst_perr", protocol_err, 0);
        datain_d = '0;
        #50;
        @(negedge clk);
        rst_n = 1'b1;
        acc_m = 0;
        exp_err = 1'b0;
        repeat (5) @(negedge clk);
        xfer(5, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
